// File: rtl/fir4_avg_post_if.sv
// rtl/fir4_avg_post_if.sv - FIR sum input and averaged ready/valid output bundle for fir4_avg_post.
interface fir4_avg_post_if #(
  parameter int w     = 16,
  parameter int DEPTH = 4
);
  logic signed [w+1:0]          s;
  logic signed [w-1:0]          y;
  logic                         y_valid;
  logic                         y_ready;
  logic [$clog2(DEPTH):0]       level;
  logic [7:0]                   drop_cnt;

  modport master (
    input  s,
    input  y_ready,
    output y,
    output y_valid,
    output level,
    output drop_cnt
  );

  modport slave (
    output s,
    output y_ready,
    input  y,
    input  y_valid,
    input  level,
    input  drop_cnt
  );
endinterface

// File: rtl/fir4_avg_post.sv
// rtl/fir4_avg_post.sv - FIR sum warm-up discard, divide-by-4 rounding and output FIFO.
// Define FIR_AVG_CONV_ROUND_EN for round-half-to-even; default is round-half-up.
module fir4_avg_post #(
  parameter int w     = 16,
  parameter int SKIP  = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  fir4_avg_post_if.master  bus
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [2:0]      SKIP_C  = 3'(SKIP);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);

  logic [2:0]          warm_q, warm_d;
  logic signed [w-1:0] r_q, r_d;
  logic                rv_q, rv_d;
  logic signed [w-1:0] mem_q [DEPTH];
  logic signed [w-1:0] mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic [7:0]          drop_q, drop_d;

  logic                empty, full, push, pop;
  logic signed [w-1:0] rnd;

`ifdef FIR_AVG_CONV_ROUND_EN
  logic signed [w-1:0] quo;
  logic [1:0]          frac;

  // Ties (frac == 2) go to the even quotient.
  always_comb begin
    quo  = bus.s[w+1:2];
    frac = bus.s[1:0];
    rnd  = quo;
    if (frac == 2'd3 || (frac == 2'd2 && quo[0])) begin
      rnd = quo + w'(1);
    end
  end
`else
  logic signed [w+1:0] sum;

  always_comb begin
    sum = bus.s + (w+2)'(2);
    rnd = w'(sum >>> 2);
  end
`endif

  always_comb begin
    warm_d   = warm_q;
    r_d      = r_q;
    rv_d     = 1'b0;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;

    empty = (level_q == '0);
    full  = (level_q == DEPTH_C);
    pop   = !empty && bus.y_ready;
    // A full FIFO still takes the new sample when the head leaves on the same edge.
    push  = rv_q && (!full || pop);

    if (warm_q < SKIP_C) begin
      warm_d = warm_q + 3'd1;
    end else begin
      rv_d = 1'b1;
      r_d  = rnd;
    end

    if (push) begin
      mem_d[wr_ptr_q] = r_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (rv_q && !push && drop_q != 8'hff) begin
      drop_d = drop_q + 8'd1;
    end

    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q   <= '0;
      r_q      <= '0;
      rv_q     <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      warm_q   <= warm_d;
      r_q      <= r_d;
      rv_q     <= rv_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.y        = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.y_valid  = (level_q != '0);
  assign bus.level    = level_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_fir4_avg_post.sv
// tb/tb_fir4_avg_post.sv - Scoreboard bench for fir4_avg_post (w=16, SKIP=4, DEPTH=4).
module tb_fir4_avg_post;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   sb[$];

  fir4_avg_post_if #(.w(16), .DEPTH(4)) bus ();

  fir4_avg_post #(.w(16), .SKIP(4), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.y_valid && bus.y_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL y_out: got %0d expected no output", $signed(bus.y));
      end else begin
        check("y_out", int'($signed(bus.y)), sb.pop_front());
      end
    end
  end

  task automatic feed(input int sval, input bit store, input int expv);
    bus.s = 18'(sval);
    if (store) sb.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag, input int lost);
    reset = 1'b1;
    #1;
    check({tag, "_y"},       int'($signed(bus.y)), 0);
    check({tag, "_y_valid"}, int'(bus.y_valid),   0);
    check({tag, "_level"},   int'(bus.level),     0);
    check({tag, "_drop"},    int'(bus.drop_cnt),  0);
    check({tag, "_lost"},    sb.size(),           lost);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    bus.s       = '0;
    bus.y_ready = 1'b0;
    reset       = 1'b0;
    #1;
    apply_reset("rst0", 0);

    // Warm-up: four discarded samples, then 2-edge latency to y.
    bus.y_ready = 1'b1;
    feed(100, 0, 0);
    feed(104, 0, 0);
    feed(108, 0, 0);
    feed(112, 0, 0);
    feed(116, 1, 29);
    check("warm_lat1_valid", int'(bus.y_valid), 0);
    feed(120, 1, 30);
    check("warm_lat2_valid", int'(bus.y_valid), 1);
    check("warm_lat2_y", int'($signed(bus.y)), 29);
    check("warm_stream_level", int'(bus.level), 1);
    feed(0, 1, 0);
    feed(0, 1, 0);
    #2;
    apply_reset("rst1", 2);

    // Rounding and extremes.
    bus.y_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(0, 0, 0);
`ifdef FIR_AVG_CONV_ROUND_EN
    feed(6, 1, 2);
    feed(-6, 1, -2);
    feed(10, 1, 2);
    feed(7, 1, 2);
    feed(-7, 1, -2);
    feed(2, 1, 0);
`else
    feed(6, 1, 2);
    feed(-6, 1, -1);
    feed(10, 1, 3);
    feed(7, 1, 2);
    feed(-7, 1, -2);
    feed(2, 1, 1);
`endif
    feed(-2, 1, 0);
    feed(131068, 1, 32767);
    feed(-131072, 1, -32768);
    feed(0, 1, 0);
    feed(0, 1, 0);
    check("round_drop", int'(bus.drop_cnt), 0);
    #2;
    apply_reset("rst2", 2);

    // Overflow with y_ready held low.
    bus.y_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(0, 0, 0);
    for (int k = 0; k < 10; k++) feed(400 + 4 * k, (k < 4), 100 + k);
    check("ovf_drop9", int'(bus.drop_cnt), 5);
    feed(440, 1, 110);
    check("ovf_level", int'(bus.level), 4);
    check("ovf_drop", int'(bus.drop_cnt), 6);

    // Full FIFO: one-edge pop lets the pending sample in behind the others.
    bus.y_ready = 1'b1;
    feed(444, 0, 111);
    bus.y_ready = 1'b0;
    check("fullpp_level", int'(bus.level), 4);
    check("fullpp_drop", int'(bus.drop_cnt), 6);
    feed(448, 1, 112);
    check("fullpp_drop_next", int'(bus.drop_cnt), 7);
    bus.y_ready = 1'b1;
    feed(452, 1, 113);
    feed(456, 1, 114);
    check("drain_level", int'(bus.level), 4);
    check("drain_y", int'($signed(bus.y)), 103);

    // Mid-stream asynchronous reset with a full FIFO.
    #2;
    apply_reset("rst3", 5);

    // Warm-up restarts after release.
    bus.y_ready = 1'b1;
    feed(500, 0, 0);
    feed(504, 0, 0);
    feed(508, 0, 0);
    feed(512, 0, 0);
    check("rewarm_valid", int'(bus.y_valid), 0);
    feed(20, 1, 5);
    check("rewarm_valid2", int'(bus.y_valid), 0);
    feed(24, 1, 6);
    check("rewarm_y", int'($signed(bus.y)), 5);
    feed(0, 1, 0);
    feed(0, 1, 0);
    #2;
    apply_reset("rst4", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
